// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//
// Data-memory port bundle between the load/store access controller and the
// data memory. Carries one request channel (valid/ready) and one response
// channel (valid only, the memory never stalls a response).
//
// Signals:
//   mem_req_valid   controller -> memory  request is valid
//   mem_req_ready   memory -> controller  request accepted this cycle
//   mem_req_addr    controller -> memory  word-aligned address
//   mem_req_we      controller -> memory  1 = write, 0 = read
//   mem_req_wstrb   controller -> memory  byte strobes (0 for reads)
//   mem_req_wdata   controller -> memory  lane-replicated write data
//   mem_resp_valid  memory -> controller  load data or store ack
//   mem_resp_rdata  memory -> controller  load data word
//
// Modports:
//   master  the access controller
//   slave   the data memory
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_we;
    logic [3:0]      mem_req_wstrb;
    logic [XLEN-1:0] mem_req_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_we,
        output mem_req_wstrb,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_we,
        input  mem_req_wstrb,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-outstanding load/store access controller sitting between the memory
// issue queue and the data-memory port. Accepts one issued memory uop,
// computes the effective address, checks alignment, formats store lanes,
// runs the request/response handshake, and returns either a sign/zero
// extended load writeback or a store completion pulse. A pipeline flush
// discards whatever is in flight.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   clear_en              pipeline flush
//   issue_*               issued memory uop and its operands
//   ex_busy               back-pressure to the issue queue
//   mem (master)          data-memory request/response bundle
//   wb_valid/wb_rd_index/wb_data   registered one-cycle load writeback
//   st_done               registered one-cycle store completion
//   misalign_fault/fault_addr      registered one-cycle alignment fault
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int XLEN      = 32,
    parameter int PRF_IDX_W = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_en,

    input  logic                 issue_valid,
    input  logic                 issue_is_store,
    input  logic [1:0]           issue_size,
    input  logic                 issue_unsigned,
    input  logic [XLEN-1:0]      issue_rs1_data,
    input  logic [XLEN-1:0]      issue_rs2_data,
    input  logic [XLEN-1:0]      issue_imm,
    input  logic [PRF_IDX_W-1:0] issue_rd_index,

    output logic                 ex_busy,

    mem_access_ctrl_if.master    mem,

    output logic                 wb_valid,
    output logic [PRF_IDX_W-1:0] wb_rd_index,
    output logic [XLEN-1:0]      wb_data,
    output logic                 st_done,
    output logic                 misalign_fault,
    output logic [XLEN-1:0]      fault_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t state;
    state_t state_next;

    // Latched uop attributes
    logic                 is_store_q;
    logic [1:0]           size_q;
    logic                 unsigned_q;
    logic [1:0]           offset_q;
    logic [PRF_IDX_W-1:0] rd_q;

    // Request registers (the memory port is driven only from these)
    logic                 req_valid_q;
    logic [XLEN-1:0]      req_addr_q;
    logic                 req_we_q;
    logic [3:0]           req_wstrb_q;
    logic [XLEN-1:0]      req_wdata_q;

    // Result registers
    logic                 wb_valid_q;
    logic [PRF_IDX_W-1:0] wb_rd_q;
    logic [XLEN-1:0]      wb_data_q;
    logic                 st_done_q;
    logic                 fault_q;
    logic [XLEN-1:0]      fault_addr_q;

    // Issue-side combinational values
    logic [XLEN-1:0]      ea;
    logic                 ea_misaligned;
    logic [3:0]           fmt_wstrb;
    logic [XLEN-1:0]      fmt_wdata;

    // Response-side combinational values
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [XLEN-1:0]      load_ext;

    // FSM control strobes
    logic                 accept;
    logic                 raise_fault;
    logic                 complete;

    // Effective address wraps modulo 2^XLEN; the carry is simply dropped.
    assign ea = issue_rs1_data + issue_imm;

    always_comb begin
        ea_misaligned = 1'b0;
        case (issue_size)
            SIZE_BYTE: ea_misaligned = 1'b0;
            SIZE_HALF: ea_misaligned = ea[0];
            SIZE_WORD: ea_misaligned = (ea[1:0] != 2'b00);
            default:   ea_misaligned = 1'b1;
        endcase
    end

    // Store lane formatting: data is replicated across all lanes so the
    // strobes alone pick which bytes the memory actually writes.
    always_comb begin
        fmt_wstrb = 4'b0000;
        fmt_wdata = issue_rs2_data;
        if (issue_is_store) begin
            case (issue_size)
                SIZE_BYTE: begin
                    fmt_wstrb = 4'b0001 << ea[1:0];
                    fmt_wdata = {4{issue_rs2_data[7:0]}};
                end
                SIZE_HALF: begin
                    fmt_wstrb = 4'b0011 << ea[1:0];
                    fmt_wdata = {2{issue_rs2_data[15:0]}};
                end
                default: begin
                    fmt_wstrb = 4'b1111;
                    fmt_wdata = issue_rs2_data;
                end
            endcase
        end
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        load_byte = 8'h00;
        case (offset_q)
            2'd0: load_byte = mem.mem_resp_rdata[7:0];
            2'd1: load_byte = mem.mem_resp_rdata[15:8];
            2'd2: load_byte = mem.mem_resp_rdata[23:16];
            default: load_byte = mem.mem_resp_rdata[31:24];
        endcase
        load_half = offset_q[1] ? mem.mem_resp_rdata[31:16] : mem.mem_resp_rdata[15:0];
        case (size_q)
            SIZE_BYTE: load_ext = {{(XLEN-8){load_byte[7] & ~unsigned_q}}, load_byte};
            SIZE_HALF: load_ext = {{(XLEN-16){load_half[15] & ~unsigned_q}}, load_half};
            default:   load_ext = mem.mem_resp_rdata;
        endcase
    end

    // Next-state and control strobes. clear_en is checked first in every
    // state so a flush always beats accept, fault, and completion.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        raise_fault = 1'b0;
        complete    = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid && !clear_en) begin
                    if (ea_misaligned) begin
                        raise_fault = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (clear_en) begin
                    // Accepted requests still owe a response, so drain it.
                    state_next = mem.mem_req_ready ? DRAIN : IDLE;
                end else if (mem.mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (clear_en) begin
                    state_next = mem.mem_resp_valid ? IDLE : DRAIN;
                end else if (mem.mem_resp_valid) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (mem.mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Uop latch and request registers. The request fields are loaded once on
    // accept and then held untouched while waiting for ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_store_q  <= 1'b0;
            size_q      <= 2'd0;
            unsigned_q  <= 1'b0;
            offset_q    <= 2'd0;
            rd_q        <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wstrb_q <= 4'b0000;
            req_wdata_q <= '0;
        end else begin
            req_valid_q <= (state_next == REQ);
            if (accept) begin
                is_store_q  <= issue_is_store;
                size_q      <= issue_size;
                unsigned_q  <= issue_unsigned;
                offset_q    <= ea[1:0];
                rd_q        <= issue_rd_index;
                req_addr_q  <= {ea[XLEN-1:2], 2'b00};
                req_we_q    <= issue_is_store;
                req_wstrb_q <= fmt_wstrb;
                req_wdata_q <= fmt_wdata;
            end
        end
    end

    // Result pulses; the data/index/address fields hold between pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            st_done_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            wb_valid_q <= complete && !is_store_q;
            st_done_q  <= complete && is_store_q;
            fault_q    <= raise_fault;
            if (complete && !is_store_q) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= load_ext;
            end
            if (raise_fault) begin
                fault_addr_q <= ea;
            end
        end
    end

    assign ex_busy            = (state != IDLE);

    assign mem.mem_req_valid  = req_valid_q;
    assign mem.mem_req_addr   = req_addr_q;
    assign mem.mem_req_we     = req_we_q;
    assign mem.mem_req_wstrb  = req_wstrb_q;
    assign mem.mem_req_wdata  = req_wdata_q;

    assign wb_valid           = wb_valid_q;
    assign wb_rd_index        = wb_rd_q;
    assign wb_data            = wb_data_q;
    assign st_done            = st_done_q;
    assign misalign_fault     = fault_q;
    assign fault_addr         = fault_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed self-checking bench for mem_access_ctrl. The bench plays the
// memory side by hand, cycle by cycle, with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int XLEN      = 32;
    localparam int PRF_IDX_W = 7;

    logic                 clock;
    logic                 reset;
    logic                 clear_en;
    logic                 issue_valid;
    logic                 issue_is_store;
    logic [1:0]           issue_size;
    logic                 issue_unsigned;
    logic [XLEN-1:0]      issue_rs1_data;
    logic [XLEN-1:0]      issue_rs2_data;
    logic [XLEN-1:0]      issue_imm;
    logic [PRF_IDX_W-1:0] issue_rd_index;
    logic                 ex_busy;
    logic                 wb_valid;
    logic [PRF_IDX_W-1:0] wb_rd_index;
    logic [XLEN-1:0]      wb_data;
    logic                 st_done;
    logic                 misalign_fault;
    logic [XLEN-1:0]      fault_addr;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl_if #(.XLEN(XLEN)) mem ();

    mem_access_ctrl #(.XLEN(XLEN), .PRF_IDX_W(PRF_IDX_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .clear_en       (clear_en),
        .issue_valid    (issue_valid),
        .issue_is_store (issue_is_store),
        .issue_size     (issue_size),
        .issue_unsigned (issue_unsigned),
        .issue_rs1_data (issue_rs1_data),
        .issue_rs2_data (issue_rs2_data),
        .issue_imm      (issue_imm),
        .issue_rd_index (issue_rd_index),
        .ex_busy        (ex_busy),
        .mem            (mem.master),
        .wb_valid       (wb_valid),
        .wb_rd_index    (wb_rd_index),
        .wb_data        (wb_data),
        .st_done        (st_done),
        .misalign_fault (misalign_fault),
        .fault_addr     (fault_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] rs1, input logic [31:0] imm,
                               input logic [31:0] rs2, input logic [6:0] rd);
        issue_valid    = 1'b1;
        issue_is_store = st;
        issue_size     = sz;
        issue_unsigned = uns;
        issue_rs1_data = rs1;
        issue_imm      = imm;
        issue_rs2_data = rs2;
        issue_rd_index = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        if (ex_busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", ex_busy); errors++; end checks++;
        if (mem.mem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid got %b exp 0", mem.mem_req_valid); errors++; end checks++;
        if (mem.mem_req_addr !== 32'h0) begin $display("FAIL reset_addr got %h exp 0", mem.mem_req_addr); errors++; end checks++;
        if ({wb_valid, st_done, misalign_fault} !== 3'b000) begin $display("FAIL reset_pulses got %b exp 000", {wb_valid, st_done, misalign_fault}); errors++; end checks++;
        if ({wb_data, fault_addr} !== 64'h0) begin $display("FAIL reset_data got %h exp 0", {wb_data, fault_addr}); errors++; end checks++;
        reset = 1'b0;
        tick();
        if (ex_busy !== 1'b0) begin $display("FAIL post_reset_busy got %b exp 0", ex_busy); errors++; end checks++;
    endtask

    // Full load transaction: issue at T, ready at T+1, response at T+2.
    task automatic test_load(input string tag, input logic [31:0] rs1, input logic [31:0] imm,
                             input logic [1:0] sz, input logic uns, input logic [6:0] rd,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
        drive_issue(1'b0, sz, uns, rs1, imm, 32'h0, rd);
        tick();
        issue_valid = 1'b0;
        if (mem.mem_req_valid !== 1'b1) begin $display("FAIL %s req_valid got %b exp 1", tag, mem.mem_req_valid); errors++; end checks++;
        if (mem.mem_req_addr !== exp_addr) begin $display("FAIL %s addr got %h exp %h", tag, mem.mem_req_addr, exp_addr); errors++; end checks++;
        if ({mem.mem_req_we, mem.mem_req_wstrb} !== 5'b0) begin $display("FAIL %s we_wstrb got %b exp 00000", tag, {mem.mem_req_we, mem.mem_req_wstrb}); errors++; end checks++;
        if (ex_busy !== 1'b1) begin $display("FAIL %s busy got %b exp 1", tag, ex_busy); errors++; end checks++;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        if (mem.mem_req_valid !== 1'b0) begin $display("FAIL %s req_drop got %b exp 0", tag, mem.mem_req_valid); errors++; end checks++;
        mem.mem_resp_valid = 1'b1;
        mem.mem_resp_rdata = rdata;
        tick();
        mem.mem_resp_valid = 1'b0;
        if (wb_valid !== 1'b1) begin $display("FAIL %s wb_valid got %b exp 1", tag, wb_valid); errors++; end checks++;
        if (wb_data !== exp_data) begin $display("FAIL %s wb_data got %h exp %h", tag, wb_data, exp_data); errors++; end checks++;
        if (wb_rd_index !== rd) begin $display("FAIL %s wb_rd got %0d exp %0d", tag, wb_rd_index, rd); errors++; end checks++;
        if ({st_done, ex_busy} !== 2'b00) begin $display("FAIL %s done_busy got %b exp 00", tag, {st_done, ex_busy}); errors++; end checks++;
        tick();
        if (wb_valid !== 1'b0) begin $display("FAIL %s wb_pulse_len got %b exp 0", tag, wb_valid); errors++; end checks++;
        if (wb_data !== exp_data) begin $display("FAIL %s wb_data_hold got %h exp %h", tag, wb_data, exp_data); errors++; end checks++;
    endtask

    task automatic test_store(input string tag, input logic [31:0] rs1, input logic [31:0] imm,
                              input logic [1:0] sz, input logic [31:0] rs2,
                              input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata);
        drive_issue(1'b1, sz, 1'b0, rs1, imm, rs2, 7'd0);
        tick();
        issue_valid = 1'b0;
        if (mem.mem_req_valid !== 1'b1) begin $display("FAIL %s req_valid got %b exp 1", tag, mem.mem_req_valid); errors++; end checks++;
        if (mem.mem_req_addr !== exp_addr) begin $display("FAIL %s addr got %h exp %h", tag, mem.mem_req_addr, exp_addr); errors++; end checks++;
        if (mem.mem_req_we !== 1'b1) begin $display("FAIL %s we got %b exp 1", tag, mem.mem_req_we); errors++; end checks++;
        if (mem.mem_req_wstrb !== exp_strb) begin $display("FAIL %s wstrb got %b exp %b", tag, mem.mem_req_wstrb, exp_strb); errors++; end checks++;
        if (mem.mem_req_wdata !== exp_wdata) begin $display("FAIL %s wdata got %h exp %h", tag, mem.mem_req_wdata, exp_wdata); errors++; end checks++;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({st_done, wb_valid, ex_busy} !== 3'b100) begin $display("FAIL %s done got %b exp 100", tag, {st_done, wb_valid, ex_busy}); errors++; end checks++;
        tick();
        if (st_done !== 1'b0) begin $display("FAIL %s done_pulse_len got %b exp 0", tag, st_done); errors++; end checks++;
    endtask

    task automatic test_misaligned();
        drive_issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 7'd1);
        tick();
        if ({misalign_fault, mem.mem_req_valid, ex_busy} !== 3'b100) begin $display("FAIL mis_word got %b exp 100", {misalign_fault, mem.mem_req_valid, ex_busy}); errors++; end checks++;
        if (fault_addr !== 32'h3001) begin $display("FAIL mis_word_addr got %h exp 00003001", fault_addr); errors++; end checks++;
        drive_issue(1'b1, 2'd3, 1'b0, 32'h4000, 32'h0, 32'h0, 7'd1);
        tick();
        if ({misalign_fault, mem.mem_req_valid, ex_busy} !== 3'b100) begin $display("FAIL mis_size3 got %b exp 100", {misalign_fault, mem.mem_req_valid, ex_busy}); errors++; end checks++;
        if (fault_addr !== 32'h4000) begin $display("FAIL mis_size3_addr got %h exp 00004000", fault_addr); errors++; end checks++;
        drive_issue(1'b0, 2'd1, 1'b0, 32'h3100, 32'h3, 32'h0, 7'd1);
        tick();
        issue_valid = 1'b0;
        if (fault_addr !== 32'h3103) begin $display("FAIL mis_half_addr got %h exp 00003103", fault_addr); errors++; end checks++;
        tick();
        if ({misalign_fault, mem.mem_req_valid, ex_busy} !== 3'b000) begin $display("FAIL mis_pulse_len got %b exp 000", {misalign_fault, mem.mem_req_valid, ex_busy}); errors++; end checks++;
        if (fault_addr !== 32'h3103) begin $display("FAIL mis_addr_hold got %h exp 00003103", fault_addr); errors++; end checks++;
        drive_issue(1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 32'h0, 7'd1);
        clear_en = 1'b1;
        tick();
        issue_valid = 1'b0;
        clear_en = 1'b0;
        if ({misalign_fault, mem.mem_req_valid, ex_busy} !== 3'b000) begin $display("FAIL mis_flushed got %b exp 000", {misalign_fault, mem.mem_req_valid, ex_busy}); errors++; end checks++;
    endtask

    task automatic test_back_pressure();
        drive_issue(1'b1, 2'd2, 1'b0, 32'h5000, 32'h4, 32'h1234_5678, 7'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            issue_valid = (i == 0);
            if (i == 0) drive_issue(1'b0, 2'd0, 1'b0, 32'h9000, 32'h0, 32'h0, 7'd9);
            if ({mem.mem_req_valid, ex_busy} !== 2'b11) begin $display("FAIL bp_valid_busy[%0d] got %b exp 11", i, {mem.mem_req_valid, ex_busy}); errors++; end checks++;
            if ({mem.mem_req_addr, mem.mem_req_wstrb, mem.mem_req_wdata} !== {32'h5004, 4'hF, 32'h1234_5678}) begin $display("FAIL bp_hold[%0d] got %h/%b/%h exp 00005004/1111/12345678", i, mem.mem_req_addr, mem.mem_req_wstrb, mem.mem_req_wdata); errors++; end checks++;
        end
        issue_valid = 1'b0;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({st_done, wb_valid, ex_busy} !== 3'b100) begin $display("FAIL bp_done got %b exp 100", {st_done, wb_valid, ex_busy}); errors++; end checks++;
        tick();
        if ({mem.mem_req_valid, ex_busy, wb_valid} !== 3'b000) begin $display("FAIL bp_ignored_issue got %b exp 000", {mem.mem_req_valid, ex_busy, wb_valid}); errors++; end checks++;
    endtask

    task automatic test_back_to_back();
        drive_issue(1'b0, 2'd2, 1'b0, 32'h8000, 32'h0, 32'h0, 7'd11);
        tick();
        issue_valid = 1'b0;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1;
        mem.mem_resp_rdata = 32'hA5A5_0001;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({wb_valid, ex_busy} !== 2'b10) begin $display("FAIL b2b_first got %b exp 10", {wb_valid, ex_busy}); errors++; end checks++;
        if (wb_data !== 32'hA5A5_0001) begin $display("FAIL b2b_first_data got %h exp a5a50001", wb_data); errors++; end checks++;
        drive_issue(1'b0, 2'd2, 1'b0, 32'h8010, 32'h0, 32'h0, 7'd12);
        tick();
        issue_valid = 1'b0;
        if ({mem.mem_req_valid, ex_busy} !== 2'b11) begin $display("FAIL b2b_second_req got %b exp 11", {mem.mem_req_valid, ex_busy}); errors++; end checks++;
        if (mem.mem_req_addr !== 32'h8010) begin $display("FAIL b2b_second_addr got %h exp 00008010", mem.mem_req_addr); errors++; end checks++;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1;
        mem.mem_resp_rdata = 32'h0000_0002;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({wb_valid, wb_rd_index, wb_data} !== {1'b1, 7'd12, 32'h2}) begin $display("FAIL b2b_second_wb got %b/%0d/%h exp 1/12/00000002", wb_valid, wb_rd_index, wb_data); errors++; end checks++;
        tick();
    endtask

    task automatic test_flush_wait();
        drive_issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0, 32'h0, 7'd3);
        tick();
        issue_valid = 1'b0;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        clear_en = 1'b1;
        tick();
        clear_en = 1'b0;
        if ({ex_busy, mem.mem_req_valid, wb_valid} !== 3'b100) begin $display("FAIL flw_drain got %b exp 100", {ex_busy, mem.mem_req_valid, wb_valid}); errors++; end checks++;
        tick();
        if (ex_busy !== 1'b1) begin $display("FAIL flw_drain_hold got %b exp 1", ex_busy); errors++; end checks++;
        mem.mem_resp_valid = 1'b1;
        mem.mem_resp_rdata = 32'h1111_1111;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({ex_busy, wb_valid, st_done} !== 3'b000) begin $display("FAIL flw_discard got %b exp 000", {ex_busy, wb_valid, st_done}); errors++; end checks++;
        tick();
        if (wb_valid !== 1'b0) begin $display("FAIL flw_late_wb got %b exp 0", wb_valid); errors++; end checks++;
        // Flush arriving together with the response
        drive_issue(1'b0, 2'd2, 1'b0, 32'h6100, 32'h0, 32'h0, 7'd4);
        tick();
        issue_valid = 1'b0;
        mem.mem_req_ready = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        mem.mem_resp_valid = 1'b1;
        clear_en = 1'b1;
        tick();
        mem.mem_resp_valid = 1'b0;
        clear_en = 1'b0;
        if ({ex_busy, wb_valid} !== 2'b00) begin $display("FAIL flw_same_cycle got %b exp 00", {ex_busy, wb_valid}); errors++; end checks++;
    endtask

    task automatic test_wrap_flush_req();
        drive_issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 7'd6);
        tick();
        issue_valid = 1'b0;
        if ({mem.mem_req_valid, mem.mem_req_addr} !== {1'b1, 32'h4}) begin $display("FAIL wrap_addr got %b/%h exp 1/00000004", mem.mem_req_valid, mem.mem_req_addr); errors++; end checks++;
        clear_en = 1'b1;
        tick();
        clear_en = 1'b0;
        if ({mem.mem_req_valid, ex_busy} !== 2'b00) begin $display("FAIL flr_withdraw got %b exp 00", {mem.mem_req_valid, ex_busy}); errors++; end checks++;
        // Stray response in IDLE must be ignored
        mem.mem_resp_valid = 1'b1;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({wb_valid, st_done, ex_busy} !== 3'b000) begin $display("FAIL flr_stray_resp got %b exp 000", {wb_valid, st_done, ex_busy}); errors++; end checks++;
        // Flush on the same cycle the request is accepted
        drive_issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 32'h0, 7'd7);
        tick();
        issue_valid = 1'b0;
        mem.mem_req_ready = 1'b1;
        clear_en = 1'b1;
        tick();
        mem.mem_req_ready = 1'b0;
        clear_en = 1'b0;
        if ({mem.mem_req_valid, ex_busy} !== 2'b01) begin $display("FAIL flr_ready_drain got %b exp 01", {mem.mem_req_valid, ex_busy}); errors++; end checks++;
        mem.mem_resp_valid = 1'b1;
        tick();
        mem.mem_resp_valid = 1'b0;
        if ({wb_valid, ex_busy} !== 2'b00) begin $display("FAIL flr_ready_discard got %b exp 00", {wb_valid, ex_busy}); errors++; end checks++;
        // Issue during IDLE with flush is dropped
        drive_issue(1'b0, 2'd2, 1'b0, 32'h7100, 32'h0, 32'h0, 7'd7);
        clear_en = 1'b1;
        tick();
        issue_valid = 1'b0;
        clear_en = 1'b0;
        if ({mem.mem_req_valid, ex_busy} !== 2'b00) begin $display("FAIL flr_idle_drop got %b exp 00", {mem.mem_req_valid, ex_busy}); errors++; end checks++;
    endtask

    task automatic test_reset_mid();
        drive_issue(1'b1, 2'd2, 1'b0, 32'hA000, 32'h0, 32'hFFFF_FFFF, 7'd0);
        tick();
        issue_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if ({mem.mem_req_valid, ex_busy, mem.mem_req_we, mem.mem_req_wstrb} !== 7'b0) begin $display("FAIL rst_mid_ctrl got %b exp 0000000", {mem.mem_req_valid, ex_busy, mem.mem_req_we, mem.mem_req_wstrb}); errors++; end checks++;
        if ({mem.mem_req_addr, mem.mem_req_wdata, wb_data, fault_addr} !== 128'h0) begin $display("FAIL rst_mid_data got %h exp 0", {mem.mem_req_addr, mem.mem_req_wdata, wb_data, fault_addr}); errors++; end checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        clear_en           = 1'b0;
        issue_valid        = 1'b0;
        issue_is_store     = 1'b0;
        issue_size         = 2'd0;
        issue_unsigned     = 1'b0;
        issue_rs1_data     = '0;
        issue_rs2_data     = '0;
        issue_imm          = '0;
        issue_rd_index     = '0;
        mem.mem_req_ready  = 1'b0;
        mem.mem_resp_valid = 1'b0;
        mem.mem_resp_rdata = '0;

        test_reset();
        test_load("ld_sbyte3", 32'h1000, 32'h3, 2'd0, 1'b0, 7'd5, 32'h80FF_1234, 32'h1000, 32'hFFFF_FF80);
        test_load("ld_ubyte1", 32'h1000, 32'h1, 2'd0, 1'b1, 7'd6, 32'h80FF_1234, 32'h1000, 32'h0000_0012);
        test_load("ld_sbyte2", 32'h1000, 32'h2, 2'd0, 1'b0, 7'd7, 32'h80FF_1234, 32'h1000, 32'hFFFF_FFFF);
        test_load("ld_uhalf2", 32'h1000, 32'h2, 2'd1, 1'b1, 7'd9, 32'h80FF_1234, 32'h1000, 32'h0000_80FF);
        test_load("ld_shalf0", 32'h1100, 32'h0, 2'd1, 1'b0, 7'd10, 32'h0000_9ABC, 32'h1100, 32'hFFFF_9ABC);
        test_load("ld_word", 32'h1200, 32'hFFFF_FFFC, 2'd2, 1'b0, 7'd127, 32'hCAFE_F00D, 32'h11FC, 32'hCAFE_F00D);
        test_store("st_half2", 32'h2000, 32'h2, 2'd1, 32'hDEAD_BEEF, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
        test_store("st_half0", 32'h2000, 32'h0, 2'd1, 32'hDEAD_BEEF, 32'h2000, 4'b0011, 32'hBEEF_BEEF);
        test_store("st_byte1", 32'h2000, 32'h1, 2'd0, 32'h0000_00AB, 32'h2000, 4'b0010, 32'hABAB_ABAB);
        test_store("st_word", 32'h2004, 32'h0, 2'd2, 32'h1234_5678, 32'h2004, 4'b1111, 32'h1234_5678);
        test_misaligned();
        test_back_pressure();
        test_back_to_back();
        test_flush_wait();
        test_wrap_flush_req();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
